// File: rtl/taxi_eth_tx_sched_pkg.sv
// Shared types and helpers for the 10G transmit frame scheduler.
//   state_t   : arbiter FSM states
//   pick_t    : result of the rotating-priority search (found flag + index)
//   rr_first  : first set request strictly after 'last', searching cyclically
package taxi_eth_tx_sched_pkg;

    localparam int PAUSE_QUANTA_W = 16;
    localparam int MAX_Q          = 8;

    typedef enum logic {
        STATE_IDLE,
        STATE_XFER
    } state_t;

    typedef struct packed {
        logic       found;
        logic [2:0] idx;
    } pick_t;

    // Rotating-priority search over the low n bits of req. Passing
    // last = n-1 turns it into a plain lowest-index-first search, which is
    // how strict priority reuses the same logic.
    function automatic pick_t rr_first(input logic [MAX_Q-1:0] req,
                                       input logic [2:0]       last,
                                       input int unsigned      n);
        pick_t      res;
        logic [3:0] cand;
        res = '0;
        for (int unsigned k = 1; k <= MAX_Q; k++) begin
            cand = {1'b0, last} + 4'(k);
            if (cand >= 4'(n)) begin
                cand = cand - 4'(n);
            end
            if (k <= n && !res.found && req[cand[2:0]]) begin
                res.found = 1'b1;
                res.idx   = cand[2:0];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/taxi_eth_tx_sched_if.sv
// AXI-stream bundle, LANES streams wide. The scheduler uses one instance
// with LANES=N for its queue inputs and one with LANES=1 for the MAC side.
//   tdata/tkeep : lane i at [i*DATA_W +: DATA_W] / [i*KEEP_W +: KEEP_W]
//   tvalid/tready/tlast/tuser : one bit per lane
//   master : drives data and valid, receives ready
//   slave  : receives data and valid, drives ready
interface taxi_eth_tx_sched_if #(
    parameter int LANES  = 1,
    parameter int DATA_W = 64,
    parameter int KEEP_W = DATA_W / 8
) ();

    logic [LANES*DATA_W-1:0] tdata;
    logic [LANES*KEEP_W-1:0] tkeep;
    logic [LANES-1:0]        tvalid;
    logic [LANES-1:0]        tready;
    logic [LANES-1:0]        tlast;
    logic [LANES-1:0]        tuser;

    modport master (output tdata, tkeep, tvalid, tlast, tuser, input tready);
    modport slave  (input tdata, tkeep, tvalid, tlast, tuser, output tready);

endinterface

// File: rtl/taxi_eth_pause_timer.sv
// Per-queue 802.3x / PFC pause timer.
//   clk, rst_n : transmit clock, async active-low reset
//   load       : pause frame received; loads quanta and restarts the prescaler
//   quanta     : pause time in 512-bit-time quanta
//   paused     : registered, high while the quanta counter is nonzero
module taxi_eth_pause_timer
    import taxi_eth_tx_sched_pkg::*;
#(
    parameter int QUANTA_CYC = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      load,
    input  logic [PAUSE_QUANTA_W-1:0] quanta,
    output logic                      paused
);

    localparam int PRESC_W = (QUANTA_CYC > 1) ? $clog2(QUANTA_CYC) : 1;

    logic [PAUSE_QUANTA_W-1:0] timer_q, timer_d;
    logic [PRESC_W-1:0]        presc_q, presc_d;
    logic                      paused_q, paused_d;

    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        timer_d = timer_q;
        presc_d = presc_q;
        if (load) begin
            // A load overrides a decrement due in the same cycle.
            timer_d = quanta;
            presc_d = '0;
        end else if (timer_q != '0) begin
            if (presc_q == PRESC_W'(QUANTA_CYC - 1)) begin
                presc_d = '0;
                timer_d = timer_q - 1'b1;
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end
        paused_d = (timer_d != '0);
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_q  <= '0;
            presc_q  <= '0;
            paused_q <= 1'b0;
        end else begin
            timer_q  <= timer_d;
            presc_q  <= presc_d;
            paused_q <= paused_d;
        end
    end

    assign paused = paused_q;

endmodule

// File: rtl/taxi_eth_tx_sched.sv
// Frame-level transmit scheduler: N queues share one MAC transmit stream.
// A queue is picked in IDLE (round-robin or strict priority) and its whole
// frame is forwarded through a combinational mux before the next pick.
//   clk, rst_n    : MAC transmit clock, async active-low reset
//   s_axis        : N queue streams (slave side)
//   m_axis        : stream to the MAC transmit sink (master side)
//   pause_req     : per-queue pause frame pulse; pause_quanta sampled with it
//   cfg_enable    : 0 blocks new grants, the frame in flight completes
//   cfg_strict    : 0 round-robin, 1 strict priority (queue 0 highest)
//   sts_paused    : per-queue pause timer nonzero
//   sts_active    : a frame is in transfer; sts_active_q is the granted queue
//   stat_frame    : one-cycle pulse after the tlast beat of queue i is taken
module taxi_eth_tx_sched
    import taxi_eth_tx_sched_pkg::*;
#(
    parameter int N          = 4,
    parameter int DATA_W     = 64,
    parameter int KEEP_W     = DATA_W / 8,
    parameter int QUANTA_CYC = 512 / DATA_W,
    parameter int SEL_W      = $clog2(N)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    taxi_eth_tx_sched_if.slave            s_axis,
    taxi_eth_tx_sched_if.master           m_axis,
    input  logic [N-1:0]                  pause_req,
    input  logic [N*PAUSE_QUANTA_W-1:0]   pause_quanta,
    input  logic                          cfg_enable,
    input  logic                          cfg_strict,
    output logic [N-1:0]                  sts_paused,
    output logic                          sts_active,
    output logic [SEL_W-1:0]              sts_active_q,
    output logic [N-1:0]                  stat_frame
);

    state_t           state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [SEL_W-1:0] last_q, last_d;
    logic [N-1:0]     stat_frame_q, stat_frame_d;

    logic [N-1:0]     eligible;
    logic [2:0]       search_from;
    pick_t            pick;
    logic             out_valid;
    logic             out_last;
    logic             frame_end;
    logic [N-1:0]     s_ready;

    // NOTE: the pause timers have no memory arrays; every counter bit is
    // reset so a paused queue can never survive a reset.
    for (genvar i = 0; i < N; i++) begin : g_pause
        taxi_eth_pause_timer #(
            .QUANTA_CYC (QUANTA_CYC)
        ) u_pause_timer (
            .clk    (clk),
            .rst_n  (rst_n),
            .load   (pause_req[i]),
            .quanta (pause_quanta[i*PAUSE_QUANTA_W +: PAUSE_QUANTA_W]),
            .paused (sts_paused[i])
        );
    end

    // Data path: the granted queue is muxed straight through, so there is
    // no per-beat latency. Valid and ready are gated to XFER only.
    always_comb begin
        out_valid = (state_q == STATE_XFER) && s_axis.tvalid[sel_q];
        out_last  = s_axis.tlast[sel_q];
        s_ready   = '0;
        if (state_q == STATE_XFER) begin
            s_ready[sel_q] = m_axis.tready;
        end
        frame_end = out_valid && m_axis.tready && out_last;
    end

    assign m_axis.tdata  = s_axis.tdata[int'(sel_q)*DATA_W +: DATA_W];
    assign m_axis.tkeep  = s_axis.tkeep[int'(sel_q)*KEEP_W +: KEEP_W];
    assign m_axis.tvalid = out_valid;
    assign m_axis.tlast  = out_last;
    assign m_axis.tuser  = s_axis.tuser[sel_q];
    assign s_axis.tready = s_ready;

    // Arbitration and frame tracking. Pause, enable and strict mode are
    // looked at only in IDLE, so a granted frame always runs to tlast.
    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        last_d       = last_q;
        stat_frame_d = '0;

        eligible    = s_axis.tvalid & ~sts_paused & {N{cfg_enable}};
        search_from = cfg_strict ? 3'(N - 1) : 3'(last_q);
        pick        = rr_first(MAX_Q'(eligible), search_from, N);

        unique case (state_q)
            STATE_IDLE: begin
                if (pick.found) begin
                    sel_d   = SEL_W'(pick.idx);
                    state_d = STATE_XFER;
                end
            end
            STATE_XFER: begin
                if (frame_end) begin
                    last_d              = sel_q;
                    stat_frame_d[sel_q] = 1'b1;
                    state_d             = STATE_IDLE;
                end
            end
            default: state_d = STATE_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= STATE_IDLE;
            sel_q        <= '0;
            last_q       <= SEL_W'(N - 1);
            stat_frame_q <= '0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            last_q       <= last_d;
            stat_frame_q <= stat_frame_d;
        end
    end

    assign sts_active   = (state_q == STATE_XFER);
    assign sts_active_q = sel_q;
    assign stat_frame   = stat_frame_q;

endmodule
